// File: rtl/cv32e40x_instr_obi_adapter.sv
// Instruction-side OBI adapter: turns the prefetcher's valid/ready/addr handshake into an
// OBI address phase. Once a request is raised it holds req/addr stable until granted, and
// it limits how many granted transactions may await rvalid. Responses are passed straight
// through to the prefetcher with no buffering.
module cv32e40x_instr_obi_adapter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                       clk,
    input  logic                                       rst_n,

    // Prefetcher transaction interface
    input  logic                                       trans_valid_i,
    output logic                                       trans_ready_o,
    input  logic [31:0]                                trans_addr_i,

    // Response interface back to the prefetcher
    output logic                                       resp_valid_o,
    output logic [31:0]                                resp_rdata_o,
    output logic                                       resp_err_o,

    // OBI instruction bus
    output logic                                       instr_req_o,
    input  logic                                       instr_gnt_i,
    output logic [31:0]                                instr_addr_o,
    input  logic                                       instr_rvalid_i,
    input  logic [31:0]                                instr_rdata_i,
    input  logic                                       instr_err_i,

    // Status
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding_cnt_o,
    output logic                                       busy_o,
    output logic                                       protocol_err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // TRANSPARENT: bus follows the prefetcher combinationally.
    // REGISTERED: an ungranted request is being held on the bus from addr_q.
    typedef enum logic [0:0] {
        StTransparent,
        StRegistered
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             perr_q, perr_d;

    logic             full;
    logic             bus_hs;

    // A response arriving this cycle does not free a slot until next cycle.
    assign full   = (cnt_q == CNT_MAX);
    assign bus_hs = instr_req_o && instr_gnt_i;

    // State, held address, outstanding counter and sticky protocol error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StTransparent;
            addr_q  <= 32'h0;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
        end
    end

    // Address-phase FSM: next state, held address capture and bus/handshake outputs
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        instr_req_o   = 1'b0;
        instr_addr_o  = trans_addr_i;
        trans_ready_o = 1'b0;

        unique case (state_q)
            StTransparent: begin
                instr_req_o   = trans_valid_i && !full;
                instr_addr_o  = trans_addr_i;
                trans_ready_o = instr_gnt_i && !full;
                if (instr_req_o && !instr_gnt_i) begin
                    // Freeze the address so a prefetcher branch cannot disturb the bus.
                    addr_d  = trans_addr_i;
                    state_d = StRegistered;
                end
            end
            StRegistered: begin
                // The slot was reserved when req first went high, so full is not consulted.
                instr_req_o   = 1'b1;
                instr_addr_o  = addr_q;
                trans_ready_o = 1'b0;
                if (instr_gnt_i) begin
                    state_d = StTransparent;
                end
            end
            default: begin
                state_d = StTransparent;
            end
        endcase
    end

    // Outstanding counter: +1 per bus grant, -1 per rvalid, saturating at both ends
    always_comb begin
        cnt_d  = cnt_q;
        perr_d = perr_q;

        if (instr_rvalid_i && (cnt_q == '0)) begin
            // Response with nothing outstanding: flag it and never underflow.
            perr_d = 1'b1;
        end

        if (bus_hs && !instr_rvalid_i) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (!bus_hs && instr_rvalid_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    // Zero-latency response pass-through and status outputs
    always_comb begin
        resp_valid_o      = instr_rvalid_i;
        resp_rdata_o      = instr_rdata_i;
        resp_err_o        = instr_err_i;
        outstanding_cnt_o = cnt_q;
        busy_o            = (cnt_q != '0) || (state_q == StRegistered);
        protocol_err_o    = perr_q;
    end

endmodule
